// File: rtl/round_pkg.sv
// Shared definitions for the MAC5 rounding scheduler.
//   WIDTH      : data width of one lane (the rounding map covers 4-bit codes only)
//   NREQ_MAX   : largest lane count the scheduler is built for
//   lane_t     : lane index wide enough for NREQ_MAX lanes
//   round_code : 4-bit rounding map, driven only by the three low bits
package round_pkg;
  localparam int WIDTH    = 4;
  localparam int NREQ_MAX = 8;

  typedef logic [$clog2(NREQ_MAX)-1:0] lane_t;

  // 000/001/010 pass through, including bit 3. 011..101 go to 4.
  // 110/111 go to 8.
  function automatic logic [3:0] round_code(input logic [3:0] a);
    logic [3:0] r;
    case (a[2:0])
      3'd0, 3'd1, 3'd2: r = a;
      3'd3, 3'd4, 3'd5: r = 4'b0100;
      default:          r = 4'b1000;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/round_sched_if.sv
// Request/response bundle between the MAC lanes and the rounding scheduler.
//   req_valid/req_data/req_ready : per-lane request handshake
//   rsp_valid/rsp_data/rsp_id    : rounded result tagged with the lane index
//   rsp_ready                    : downstream accept
// The master modport belongs to the lanes/consumer side; the slave modport
// belongs to the scheduler.
interface round_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/round_sched_rr_arbiter.sv
// Rotating-priority arbiter, purely combinational.
//   req    : per-lane request vector
//   ptr    : last granted lane; the search starts at ptr+1 and wraps
//   enable : when low no grant is issued
//   grant  : one-hot grant (all zero if nothing wins)
//   idx    : encoded index of the granted lane (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              hit;
  int                off;
  int                lane;

  always_comb begin
    // rot[i] is the request of lane (ptr+1+i) mod NREQ, so the lowest set
    // bit of rot is the winner in rotating order.
    dbl  = {req, req} >> (int'(ptr) + 1);
    rot  = dbl[NREQ-1:0];
    hit  = 1'b0;
    off  = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        off = i;
      end
    end
    lane  = (int'(ptr) + 1 + off) % NREQ;
    grant = '0;
    idx   = '0;
    if (enable && hit) begin
      grant = NREQ'(1) << lane;
      idx   = IDW'(lane);
    end
  end
endmodule

// File: rtl/round_sched.sv
// Round-robin scheduler sharing one 4-bit rounding stage among NREQ lanes.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of round_sched_if (lane requests in, tagged
//                rounded result out with downstream backpressure)
//   done_cnt   : wrap-around count of results taken downstream
// One lane is granted per cycle whenever the output register is empty or
// being drained; a drain and a new accept in the same cycle is a normal
// back-to-back transfer.
module round_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        reset,
  round_sched_if.slave bus,
  output logic [15:0] done_cnt
);
  import round_pkg::*;

  logic [IDW-1:0]   ptr;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             can_issue;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] win_data;

  assign can_issue = !rsp_valid_q || bus.rsp_ready;
  assign drain     = rsp_valid_q && bus.rsp_ready;

  // Reset gates the grant so no lane sees req_ready in the reset cycle.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .enable (can_issue && !reset),
    .grant  (grant),
    .idx    (win)
  );

  assign accept   = |grant;
  assign win_data = bus.req_data[int'(win)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      done_cnt    <= '0;
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= round_code(win_data);
        rsp_id_q    <= win;
        ptr         <= win;
      end else if (drain) begin
        rsp_valid_q <= 1'b0;
      end
      if (drain) done_cnt <= done_cnt + 16'd1;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_round_sched.sv
// Self-checking bench for round_sched: directed scenarios plus a randomized
// run, all compared against a small behavioural model of the scheduler.
module tb_round_sched;
  import round_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] done_cnt;

  round_sched_if #(.NREQ(NREQ), .WIDTH(4), .IDW(IDW)) bus ();

  round_sched #(.WIDTH(4), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus held by the bench
  logic       t_vld [NREQ];
  logic [3:0] t_dat [NREQ];
  logic       t_rdy;

  // reference model state
  int          m_last;
  logic        m_vld;
  logic [3:0]  m_data;
  lane_t       m_id;
  logic [15:0] m_cnt;

  logic [3:0] map_exp [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8,
                               4'h8, 4'h9, 4'hA, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8};

  function automatic logic [3:0] ref_round(input logic [3:0] a);
    int low;
    low = int'(a) % 8;
    if (low < 3)      return a;
    else if (low < 6) return 4'd4;
    else              return 4'd8;
  endfunction

  // Winner for the current inputs, or -1 if no lane is granted.
  function automatic int exp_grant();
    if (reset) return -1;
    if (m_vld && !t_rdy) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int l;
      l = (m_last + k) % NREQ;
      if (t_vld[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? '0 : (NREQ'(1) << g);
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = t_vld[i];
      bus.req_data[i*4 +: 4] = t_dat[i];
    end
    bus.rsp_ready = t_rdy;
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NREQ; i++) begin
      t_vld[i] = 1'b0;
      t_dat[i] = 4'h0;
    end
  endtask

  // Advance one clock and move the model along the same edge.
  task automatic tick();
    int g;
    logic [3:0] d;
    g = exp_grant();
    d = (g >= 0) ? t_dat[g] : 4'h0;
    @(posedge clk);
    if (reset) begin
      m_last = NREQ - 1;
      m_vld  = 1'b0;
      m_data = 4'h0;
      m_id   = '0;
      m_cnt  = 16'h0;
    end else begin
      if (m_vld && t_rdy) m_cnt = m_cnt + 16'd1;
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_data = ref_round(d);
        m_id   = lane_t'(g);
        m_last = g;
      end else if (m_vld && t_rdy) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply();
    tick();
    reset = 1'b0;
    apply();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      t_vld[i] = 1'b1;
      t_dat[i] = 4'(i);
    end
    t_rdy = 1'b1;
    apply();
    n_vec++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'h0 || bus.rsp_id !== 2'd0 || done_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%0d want 0,0,0,0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, done_cnt);
    end
    reset = 1'b0;
    clear_lanes();
    apply();
  endtask

  task automatic test_map_sweep();
    do_reset();
    t_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      clear_lanes();
      t_vld[0] = 1'b1;
      t_dat[0] = 4'(c);
      apply();
      n_vec++;
      if (bus.req_ready !== 4'b0001) begin
        n_err++;
        $display("FAIL map_ready code %0d: got %b want 0001", c, bus.req_ready);
      end
      tick();
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== map_exp[c] || bus.rsp_id !== 2'd0) begin
        n_err++;
        $display("FAIL map code %0d: got v=%b d=%h id=%0d want 1,%h,0",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, map_exp[c]);
      end
    end
    clear_lanes();
    apply();
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    t_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      t_vld[i] = 1'b1;
      t_dat[i] = 4'($urandom_range(0, 15));
    end
    for (int n = 0; n < 8; n++) begin
      logic [3:0] want;
      want = 4'b0001 << (n % 4);
      apply();
      n_vec++;
      if (bus.req_ready !== want) begin
        n_err++;
        $display("FAIL fair grant %0d: got %b want %b", n, bus.req_ready, want);
      end
      tick();
      n_vec++;
      if (bus.rsp_id !== 2'(n % 4) || bus.rsp_data !== m_data) begin
        n_err++;
        $display("FAIL fair rsp %0d: got id=%0d d=%h want id=%0d d=%h",
                 n, bus.rsp_id, bus.rsp_data, n % 4, m_data);
      end
    end
    clear_lanes();
    apply();
    tick();
    n_vec++;
    if (done_cnt !== 16'd8 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fair done_cnt: got %0d v=%b want 8 v=0", done_cnt, bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  hd;
    logic [1:0]  hid;
    logic [15:0] c0;
    do_reset();
    t_rdy = 1'b1;
    t_vld[1] = 1'b1;
    t_dat[1] = 4'($urandom_range(0, 15));
    apply();
    tick();
    hd  = ref_round(t_dat[1]);
    hid = 2'd1;
    clear_lanes();
    t_vld[2] = 1'b1;
    t_dat[2] = 4'($urandom_range(0, 15));
    t_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      apply();
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready cycle %0d: got %b want 0000", n, bus.req_ready);
      end
      tick();
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== hd || bus.rsp_id !== hid) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h id=%0d want 1,%h,%0d",
                 n, bus.rsp_valid, bus.rsp_data, bus.rsp_id, hd, hid);
      end
    end
    c0 = done_cnt;
    t_rdy = 1'b1;
    apply();
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== ref_round(t_dat[2]) ||
        done_cnt !== c0 + 16'd1) begin
      n_err++;
      $display("FAIL bp_b2b: got v=%b id=%0d d=%h cnt=%0d want 1,2,%h,%0d",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, done_cnt, ref_round(t_dat[2]), c0 + 16'd1);
    end
    clear_lanes();
    apply();
    tick();
  endtask

  task automatic test_sparse();
    do_reset();
    t_rdy = 1'b1;
    t_vld[1] = 1'b1;
    t_vld[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [3:0] want;
      t_dat[1] = 4'($urandom_range(0, 15));
      t_dat[3] = 4'($urandom_range(0, 15));
      want = (n % 2 == 0) ? 4'b0010 : 4'b1000;
      apply();
      n_vec++;
      if (bus.req_ready !== want) begin
        n_err++;
        $display("FAIL sparse grant %0d: got %b want %b", n, bus.req_ready, want);
      end
      tick();
    end
    clear_lanes();
    apply();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    t_rdy = 1'b1;
    t_vld[0] = 1'b1;
    t_dat[0] = 4'h7;
    apply();
    tick();
    t_rdy = 1'b0;
    apply();
    tick();
    reset = 1'b1;
    apply();
    tick();
    reset = 1'b0;
    clear_lanes();
    apply();
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || done_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid state: got v=%b cnt=%0d want 0,0", bus.rsp_valid, done_cnt);
    end
    t_vld[2] = 1'b1;
    t_vld[3] = 1'b1;
    t_rdy = 1'b1;
    apply();
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_mid grant: got %b want 0100", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL reset_mid rsp_id: got %0d want 2", bus.rsp_id);
    end
    clear_lanes();
    apply();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        t_vld[i] = 1'($urandom_range(0, 1));
        t_dat[i] = 4'($urandom_range(0, 15));
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      apply();
      n_vec++;
      if (bus.req_ready !== exp_ready()) begin
        n_err++;
        $display("FAIL rand_ready %0d: got %b want %b", n, bus.req_ready, exp_ready());
      end
      tick();
      n_vec++;
      if (bus.rsp_valid !== m_vld || bus.rsp_data !== m_data ||
          {1'b0, bus.rsp_id} !== m_id || done_cnt !== m_cnt) begin
        n_err++;
        $display("FAIL rand_rsp %0d: got v=%b d=%h id=%0d cnt=%0d want %b,%h,%0d,%0d",
                 n, bus.rsp_valid, bus.rsp_data, bus.rsp_id, done_cnt, m_vld, m_data, m_id, m_cnt);
      end
    end
    clear_lanes();
    t_rdy = 1'b1;
    apply();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    t_rdy = 1'b1;
    t_vld[0] = 1'b1;
    t_dat[0] = 4'h1;
    apply();
    // first tick only accepts; every later tick completes one transfer
    for (int n = 0; n < 65536; n++) tick();
    n_vec++;
    if (done_cnt !== 16'hFFFF || done_cnt !== m_cnt) begin
      n_err++;
      $display("FAIL wrap_pre: got %h want FFFF (model %h)", done_cnt, m_cnt);
    end
    tick();
    n_vec++;
    if (done_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap: got %h want 0000", done_cnt);
    end
    clear_lanes();
    apply();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    t_rdy = 1'b0;
    clear_lanes();
    m_last = NREQ - 1;
    m_vld  = 1'b0;
    m_data = 4'h0;
    m_id   = '0;
    m_cnt  = 16'h0;
    apply();
    test_reset();
    test_map_sweep();
    test_fairness();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/round_sched.md
# round_sched

Round-robin scheduler that shares a single 4-bit rounding stage among NREQ MAC lanes in the MAC5 inference datapath. Each lane presents a raw 4-bit accumulator value with a valid/ready handshake. The scheduler grants one lane per cycle, rounds the value into a registered output stage, and returns the result tagged with the lane index under downstream backpressure. It also keeps a wrap-around count of completed roundings for debug.

## Interface
Parameters:
- WIDTH, 4, data width; fixed at 4 because the rounding map is defined for 4-bit codes only
- NREQ, 4, number of requesting lanes (2..8)
- IDW, $clog2(NREQ), lane-index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock is clk
- req_valid  in  NREQ  per-lane request valid
- req_data  in  NREQ*WIDTH  per-lane raw value; lane i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  per-lane accept; at most one bit high in any cycle
- rsp_valid  out  1  rounded result valid
- rsp_data  out  WIDTH  rounded result
- rsp_id  out  IDW  index of the lane that produced rsp_data
- rsp_ready  in  1  downstream accept
- done_cnt  out  16  completed-response counter; wraps 0xFFFF -> 0

## Operation
- Rounding map uses a[2:0] only. Codes 000/001/010 pass a through unchanged, including a[3]. Codes 011/100/101 produce 4'b0100. Codes 110/111 produce 4'b1000.
- Output stage is a single register holding {rsp_valid, rsp_id, rsp_data}.
- can_issue = !rsp_valid || rsp_ready.
- Arbitration: when can_issue is high, the winner is the first lane with req_valid set, searching from ptr+1 upward modulo NREQ. req_ready[winner] = 1 and all other req_ready bits are 0. When can_issue is low, all req_ready bits are 0.
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready. It never depends on req_data.
- On accept (req_valid[w] & req_ready[w]):
  - capture rsp_data <= round(req_data[w]), rsp_id <= w, rsp_valid <= 1
  - ptr <= w
- If rsp_valid & rsp_ready and there is no accept: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- If rsp_valid & !rsp_ready: all output fields hold.
- done_cnt increments once per cycle in which rsp_valid & rsp_ready.
- A lane whose request is not granted keeps its data stable and req_valid high. The scheduler does not check this.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, done_cnt 0, ptr NREQ-1 (so lane 0 has first priority). req_ready is 0 for all lanes in the reset cycle.
- Latency: a request accepted at edge t appears on rsp_valid/rsp_data at t+1.
- Throughput: one result per cycle while rsp_ready stays high.
- Simultaneous drain and accept in the same cycle is a back-to-back transfer with no bubble.
- Fairness: with all lanes continuously valid and rsp_ready high, grants rotate 0,1,2,3,0,… A continuously valid lane waits at most NREQ-1 grants.
- Reset mid-operation drops the held result without delivering it. done_cnt clears. The first grant after reset goes to the lowest-indexed valid lane.

## Structure
- Shared package round_pkg:
  - WIDTH constant
  - round_code function (the map above)
  - lane-index typedef
- Sub-module rr_arbiter (NREQ):
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant, encoded index
  - purely combinational
- Top level holds ptr, the output register and done_cnt.

## Test plan
- Map sweep: lane 0 sends codes 0..15 with rsp_ready=1. Expected outputs 0,1,2,4,4,4,8,8,8,9,A,4,4,4,8,8 (hex), each one cycle after accept, rsp_id=0.
- All four lanes valid continuously, rsp_ready=1, 8 cycles. Expected grant order 0,1,2,3,0,1,2,3. done_cnt=8 after the last response is taken.
- Backpressure: rsp_valid high with rsp_ready=0 for 3 cycles. Expected: req_ready=0 throughout and rsp_data/rsp_id stable. Raising rsp_ready with lane 2 valid gives a back-to-back transfer with rsp_id=2 the next cycle.
- Sparse requests: only lanes 1 and 3 valid. Expected grants alternate 1,3,1,3 and lanes 0 and 2 never see req_ready.
- Reset while rsp_valid=1 and rsp_ready=0. Expected next cycle: rsp_valid=0, done_cnt=0. With lanes 2 and 3 valid, the next grant goes to lane 2.
- done_cnt wrap: preload via 65535 transfers (or force), then one more transfer. Expected done_cnt=0.
